// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge bundle.
//   req   : fetch request from the fetch stage
//   addr  : fetch address, held constant until acknowledged
//   ack   : transfer completes on an edge where req and ack are both high
//   rdata : instruction word, meaningful while ack is high
// master = fetch stage, slave = instruction memory.
interface imem_if #(
  parameter int ADDRESS_LEN     = 32,
  parameter int INSTRUCTION_LEN = 32
);
  logic                       req;
  logic [ADDRESS_LEN-1:0]     addr;
  logic                       ack;
  logic [INSTRUCTION_LEN-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage_module.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, fetches over a req/ack handshake that tolerates wait cycles,
// and presents pc_out/instruction/valid to decode. Bubbles (NOP, valid=0)
// are inserted whenever no real instruction is available.
//
// Ports:
//   clk            : single clock, rising edge
//   rst            : synchronous, active-low reset
//   freeze         : hazard stall, holds IF/ID and PC
//   branch_taken   : redirect from execute, also flushes IF/ID
//   branch_address : redirect target
//   imem           : instruction memory handshake (master side)
//   pc_out         : fetched address + 4 (registered)
//   instruction    : registered instruction
//   valid          : 1 = instruction is real, 0 = bubble
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | requesting imem at pc, results go straight to IF/ID
// DROP  | redirect pending; request at old pc must still complete,
//       | its data is thrown away and pc then jumps to tgt
// HOLD  | fetched word parked in skid buffer because of freeze,
//       | no request issued until it drains
module if_stage_module #(
  parameter int                         ADDRESS_LEN     = 32,
  parameter int                         INSTRUCTION_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0]     RESET_PC        = '0,
  parameter logic [INSTRUCTION_LEN-1:0] NOP_INSTR       = 32'hE1A00000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_address,
  imem_if.master                     imem,
  output logic [ADDRESS_LEN-1:0]     pc_out,
  output logic [INSTRUCTION_LEN-1:0] instruction,
  output logic                       valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDRESS_LEN-1:0] ADDR_STEP = ADDRESS_LEN'(4);

  state_t                     state, state_nxt;
  logic [ADDRESS_LEN-1:0]     pc, pc_nxt;
  logic [ADDRESS_LEN-1:0]     tgt, tgt_nxt;
  logic [INSTRUCTION_LEN-1:0] buf_instr, buf_instr_nxt;
  logic [ADDRESS_LEN-1:0]     buf_pc, buf_pc_nxt;
  logic [ADDRESS_LEN-1:0]     pc_out_nxt;
  logic [INSTRUCTION_LEN-1:0] instruction_nxt;
  logic                       valid_nxt;

  logic                       req;
  logic                       xfer;
  logic [ADDRESS_LEN-1:0]     pc_inc;

  // Request is masked during reset because the memory is reset with us and
  // any outstanding transfer is abandoned.
  assign req       = (state != HOLD) && rst;
  assign xfer      = req && imem.ack;
  assign pc_inc    = pc + ADDR_STEP;
  assign imem.req  = req;
  assign imem.addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      tgt         <= '0;
      buf_instr   <= '0;
      buf_pc      <= '0;
      pc_out      <= '0;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      tgt         <= tgt_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_pc      <= buf_pc_nxt;
      pc_out      <= pc_out_nxt;
      instruction <= instruction_nxt;
      valid       <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    tgt_nxt         = tgt;
    buf_instr_nxt   = buf_instr;
    buf_pc_nxt      = buf_pc;
    pc_out_nxt      = pc_out;
    instruction_nxt = instruction;
    valid_nxt       = valid;

    unique case (state)
      FETCH: begin
        if (branch_taken) begin
          instruction_nxt = NOP_INSTR;
          valid_nxt       = 1'b0;
          if (xfer) begin
            pc_nxt = branch_address;
          end else begin
            // Request cannot be withdrawn; wait for it in DROP.
            tgt_nxt   = branch_address;
            state_nxt = DROP;
          end
        end else if (xfer) begin
          pc_nxt = pc_inc;
          if (freeze) begin
            buf_instr_nxt = imem.rdata;
            buf_pc_nxt    = pc_inc;
            state_nxt     = HOLD;
          end else begin
            instruction_nxt = imem.rdata;
            pc_out_nxt      = pc_inc;
            valid_nxt       = 1'b1;
          end
        end else if (!freeze) begin
          instruction_nxt = NOP_INSTR;
          valid_nxt       = 1'b0;
        end
      end

      DROP: begin
        if (branch_taken) begin
          tgt_nxt = branch_address;
        end
        if (xfer) begin
          pc_nxt    = branch_taken ? branch_address : tgt;
          state_nxt = FETCH;
        end
        if (branch_taken || !freeze) begin
          instruction_nxt = NOP_INSTR;
          valid_nxt       = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_nxt          = branch_address;
          state_nxt       = FETCH;
          instruction_nxt = NOP_INSTR;
          valid_nxt       = 1'b0;
        end else if (!freeze) begin
          instruction_nxt = buf_instr;
          pc_out_nxt      = buf_pc;
          valid_nxt       = 1'b1;
          state_nxt       = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage_module.sv
module tb_if_stage_module;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  imem_if #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) imem ();

  // Memory returns the address as data when it acknowledges.
  assign imem.rdata = imem.ack ? imem.addr : 32'hBAD0BAD0;

  if_stage_module dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem           (imem.master),
    .pc_out         (pc_out),
    .instruction    (instruction),
    .valid          (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch pointer, an optional pending redirect, and a
  // parking queue for words fetched while the pipeline was frozen.
  logic [31:0] m_pc, m_tgt, m_pc_out, m_instr;
  logic        m_valid, m_kill, m_started = 1'b0;
  logic [31:0] park_instr[$];
  logic [31:0] park_pc[$];
  logic        m_req, m_acc;

  always @(posedge clk) begin
    m_req = rst && (park_pc.size() == 0);
    m_acc = m_req && imem.ack;
    if (!rst) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_kill = 1'b0;
      m_pc_out = 32'h0; m_instr = NOP; m_valid = 1'b0;
      park_instr.delete(); park_pc.delete();
    end else if (branch_taken) begin
      m_instr = NOP; m_valid = 1'b0;
      if (park_pc.size() != 0) begin
        park_instr.delete(); park_pc.delete();
        m_pc = branch_address;
      end else if (m_acc) begin
        m_pc = branch_address; m_kill = 1'b0;
      end else begin
        m_kill = 1'b1; m_tgt = branch_address;
      end
    end else if (park_pc.size() != 0) begin
      if (!freeze) begin
        m_instr = park_instr.pop_front();
        m_pc_out = park_pc.pop_front();
        m_valid = 1'b1;
      end
    end else if (m_kill) begin
      if (m_acc) begin m_pc = m_tgt; m_kill = 1'b0; end
      if (!freeze) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (m_acc) begin
      if (freeze) begin
        park_instr.push_back(m_pc);
        park_pc.push_back(m_pc + 32'd4);
      end else begin
        m_instr = m_pc; m_pc_out = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!freeze) begin
      m_instr = NOP; m_valid = 1'b0;
    end
    m_started = 1'b1;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      m_req = rst && (park_pc.size() == 0);
      check("imem_req", {31'b0, imem.req}, {31'b0, m_req});
      if (m_req) check("imem_addr", imem.addr, m_pc);
      check("pc_out", pc_out, m_pc_out);
      check("instruction", instruction, m_instr);
      check("valid", {31'b0, valid}, {31'b0, m_valid});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int ack_pct, frz_pct, br_pct, rst_pct;

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    branch_address = 32'h0; imem.ack = 1'b1;
    repeat (3) cyc();
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr", instruction, NOP);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_req", {31'b0, imem.req}, 32'h0);

    // Zero-wait streaming.
    rst = 1'b1;
    #1;
    check("first_req", {31'b0, imem.req}, 32'h1);
    check("first_addr", imem.addr, 32'h0);
    cyc();
    check("stream_pc4", pc_out, 32'h4);
    check("stream_v", {31'b0, valid}, 32'h1);
    cyc();
    check("stream_pc8", pc_out, 32'h8);
    cyc();
    check("stream_pc12", pc_out, 32'hC);
    check("stream_i8", instruction, 32'h8);

    // Freeze while an ack lands: word parked, request dropped.
    freeze = 1'b1;
    cyc();
    check("hold_req", {31'b0, imem.req}, 32'h0);
    check("hold_pc_out", pc_out, 32'hC);
    cyc();
    check("hold_instr", instruction, 32'h8);
    freeze = 1'b0;
    cyc();
    check("drain_pc_out", pc_out, 32'h10);
    check("drain_instr", instruction, 32'hC);
    check("drain_addr", imem.addr, 32'h10);

    // Branch to top of address space, then wrap.
    branch_taken = 1'b1; branch_address = 32'hFFFFFFFC;
    cyc();
    branch_taken = 1'b0;
    check("br_bubble", {31'b0, valid}, 32'h0);
    check("br_addr", imem.addr, 32'hFFFFFFFC);
    cyc();
    check("wrap_addr", imem.addr, 32'h0);
    check("wrap_pc_out", pc_out, 32'h0);
    check("wrap_instr", instruction, 32'hFFFFFFFC);

    // Randomized phases with varying memory latency and control activity.
    for (int p = 0; p < 10; p++) begin
      case (p)
        0: begin ack_pct = 100; frz_pct = 0;  br_pct = 0;  rst_pct = 0; end
        1: begin ack_pct = 33;  frz_pct = 0;  br_pct = 0;  rst_pct = 0; end
        2: begin ack_pct = 100; frz_pct = 30; br_pct = 0;  rst_pct = 0; end
        3: begin ack_pct = 40;  frz_pct = 0;  br_pct = 15; rst_pct = 0; end
        4: begin ack_pct = 30;  frz_pct = 30; br_pct = 20; rst_pct = 0; end
        5: begin ack_pct = 60;  frz_pct = 50; br_pct = 10; rst_pct = 2; end
        6: begin ack_pct = 20;  frz_pct = 20; br_pct = 30; rst_pct = 3; end
        7: begin ack_pct = 80;  frz_pct = 70; br_pct = 5;  rst_pct = 0; end
        8: begin ack_pct = 50;  frz_pct = 40; br_pct = 25; rst_pct = 5; end
        default: begin ack_pct = 70; frz_pct = 20; br_pct = 10; rst_pct = 1; end
      endcase
      for (int c = 0; c < 300; c++) begin
        imem.ack     = ($urandom_range(99) < ack_pct);
        freeze       = ($urandom_range(99) < frz_pct);
        branch_taken = ($urandom_range(99) < br_pct);
        rst          = !($urandom_range(99) < rst_pct);
        if ($urandom_range(3) == 0)
          branch_address = 32'hFFFFFFF0 | ($urandom & 32'hC);
        else
          branch_address = $urandom & 32'hFFFFFFFC;
        cyc();
      end
    end

    rst = 1'b1; imem.ack = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
